// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Control FSM for the multicycle MIPS datapath. Decodes opcode/funct from the
// instruction register, sequences each instruction through its states and
// drives every datapath select and write strobe. Handshakes with a single
// shared instruction/data memory and halts on an illegal instruction or a
// memory timeout, reporting the cause.
//
// Parameters:
//   MEM_TIMEOUT   max cycles a memory state may wait for mem_ready (0 = never)
//
// Optional build feature (macro MC_CONTROLLER_INSTRET_EN):
//   adds output instret[31:0], a count of retired instructions.
//
// Ports:
//   clk          clock
//   reset        synchronous active-low reset (0 = reset)
//   opcode       instr[31:26] from the instruction register
//   funct        instr[5:0] from the instruction register
//   zero         ALU zero flag
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access request
//   mem_write    write access (valid with mem_req)
//   i_or_d       memory address select: 0 = pc, 1 = alu_out
//   ir_write     load the instruction register
//   pc_en        load pc
//   pc_src       00 = alu result, 01 = alu_out (branch), 10 = jump target
//   alu_src_a    0 = pc, 1 = reg A
//   alu_src_b    00 = reg B, 01 = 4, 10 = sign_imm, 11 = sign_imm << 2
//   alu_control  010 add, 110 sub, 000 and, 001 or, 111 slt
//   reg_dst      register file write address: 0 = rt, 1 = rd
//   mem_to_reg   register file write data: 0 = alu_out, 1 = memory data
//   reg_write    register file write
//   halted       FSM is in HALT
//   halt_cause   00 none, 01 illegal opcode, 10 illegal funct, 11 mem timeout
//   state        current state encoding, for debug
//   instret      retired instruction count (MC_CONTROLLER_INSTRET_EN only)
// -----------------------------------------------------------------------------
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [3:0]  state
`ifdef MC_CONTROLLER_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd15
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_OPCODE  = 2'b01,
    CAUSE_FUNCT   = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Wait-count value seen on the last permitted waiting cycle; a further miss
  // on that cycle exhausts the budget.
  localparam int unsigned TIMEOUT_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  state_e      state_q, state_d;
  cause_e      cause_q, cause_d;
  logic [15:0] wait_q, wait_d;

  logic        mem_state;
  logic        mem_wait;
  logic        timeout_hit;
  logic        funct_legal;
  logic [2:0]  funct_alu;

  // {legal, alu_control} for an R-type funct; illegal codes fall back to add.
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, ALU_ADD};
      6'b100010: return {1'b1, ALU_SUB};
      6'b100100: return {1'b1, ALU_AND};
      6'b100101: return {1'b1, ALU_OR};
      6'b101010: return {1'b1, ALU_SLT};
      default:   return {1'b0, ALU_ADD};
    endcase
  endfunction

  assign {funct_legal, funct_alu} = decode_funct(funct);

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign mem_wait    = mem_state && !mem_ready;
  // mem_ready is excluded through mem_wait, so a completing access always wins.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == 16'(TIMEOUT_LAST));

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d = state_q;
    cause_d = cause_q;
    // Counts only while stalled in a memory state and clears otherwise, so it
    // is already zero on entry to FETCH, MEMRD or MEMWR. With MEM_TIMEOUT = 0
    // its value is never consulted, so a wrap is harmless.
    wait_d  = mem_wait ? wait_q + 16'd1 : 16'd0;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_HALT;
            cause_d = CAUSE_OPCODE;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXECUTE: begin
        if (funct_legal) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_HALT;
          cause_d = CAUSE_FUNCT;
        end
      end
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;  // unused encodings recover to FETCH
    endcase
  end

`ifdef MC_CONTROLLER_INSTRET_EN
  logic [31:0] instret_q;
  logic        retire;

  assign retire = (state_q == S_MEMWB)  || (state_q == S_ALUWB)  ||
                  (state_q == S_BRANCH) || (state_q == S_ADDIWB) ||
                  (state_q == S_JUMP)   || ((state_q == S_MEMWR) && mem_ready);
  assign instret = instret_q;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers take non-blocking assignments only, and reset is
    // synchronous: it acts only when sampled low on a rising clock edge.
    if (!reset) begin
      state_q   <= S_FETCH;
      cause_q   <= CAUSE_NONE;
      wait_q    <= 16'd0;
`ifdef MC_CONTROLLER_INSTRET_EN
      instret_q <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
`ifdef MC_CONTROLLER_INSTRET_EN
      // Wraps naturally at 2^32; HALT never retires, so the count freezes there.
      if (retire) instret_q <= instret_q + 32'd1;
`endif
    end
  end

  // Moore outputs decoded from the current state. FETCH and BRANCH pass
  // mem_ready / zero straight through to their strobes.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;  // branch target precomputed into alu_out
      S_MEMADR, S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;  // HALT and unused encodings: everything idle
    endcase

    // Reset low kills every strobe in the same cycle (an in-flight access is
    // dropped at once) and parks the selects at their FETCH values.
    if (!reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_en       = 1'b0;
      reg_write   = 1'b0;
      i_or_d      = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b01;
      alu_control = ALU_ADD;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
    end
  end

  assign halted     = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign state      = state_q;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Moore-style control FSM that sequences the multicycle variant of the MIPS datapath.
- Decodes opcode/funct from the instruction register and drives every datapath select and write strobe.
- Handshakes with a single shared instruction/data memory.
- Halts on illegal instructions or memory timeout and reports the cause.

Parameters:
- MEM_TIMEOUT, default 0: maximum cycles a memory state may wait for mem_ready; 0 means unlimited. Counter width is 16 bits; values 1..65535 are legal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  write access (valid with mem_req)
- i_or_d  out  1  memory address select: 0 = pc, 1 = alu_out
- ir_write  out  1  load the instruction register
- pc_en  out  1  load pc
- pc_src  out  2  00 = alu_res, 01 = alu_out (branch), 10 = jump target
- alu_src_a  out  1  0 = pc, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign_imm, 11 = sign_imm<<2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = alu_out, 1 = memory data
- reg_write  out  1  register file write
- halted  out  1  FSM is in HALT
- halt_cause  out  2  00 none, 01 illegal opcode, 10 illegal funct, 11 memory timeout
- state  out  4  current state encoding, for debug

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, HALT=15.
- Reset:
  - reset==0 at a clk edge sets state to FETCH, halt_cause to 00, and the wait counter to 0.
  - While reset==0, mem_req, mem_write, ir_write, pc_en and reg_write are forced to 0. Selects take their FETCH values.
- Default outputs: all strobes 0; selects 0; alu_control=010.
- FETCH:
  - Outputs: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, pc_src=00.
  - ir_write=pc_en=mem_ready, combinationally.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11 (branch target precomputed).
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP.
  - Any other opcode -> HALT with cause 01.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, add.
  - Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD:
  - Outputs: mem_req=1, i_or_d=1.
  - Waits for mem_ready, then -> MEMWB.
- MEMWB:
  - Outputs: reg_dst=0, mem_to_reg=1, reg_write=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: mem_req=1, mem_write=1, i_or_d=1, all held stable until mem_ready.
  - Next state: FETCH.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00.
  - alu_control from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Next state: ALUWB.
  - Any other funct -> HALT with cause 10; in that case alu_control=010.
- ALUWB:
  - Outputs: reg_dst=1, mem_to_reg=0, reg_write=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero.
  - Next state: FETCH.
- ADDIEXEC:
  - Outputs: alu_src_a=1, alu_src_b=10, add.
  - Next state: ADDIWB.
- ADDIWB:
  - Outputs: reg_dst=0, mem_to_reg=0, reg_write=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: pc_src=10, pc_en=1.
  - Next state: FETCH.
- HALT:
  - All strobes 0; halted=1; halt_cause held.
  - Only reset exits HALT.
- Latency with mem_ready tied 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Memory wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle the FSM waits with mem_ready=0.
  - When MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT with mem_ready still 0, the next state is HALT with cause 11.
  - mem_ready in that same cycle wins over timeout.
- The FSM never aborts a memory request mid-wait except by timeout or reset.
- Reset mid-access drops mem_req in the same cycle reset is low.

Optional Feature:
- Macro: MC_CONTROLLER_INSTRET_EN.
- When defined:
  - Adds output instret [31:0], reset to 0.
  - Increments by 1 on each cycle that completes an instruction: MEMWB; MEMWR with mem_ready; ALUWB; BRANCH; ADDIWB; JUMP.
  - Wraps 0xFFFFFFFF -> 0.
  - Frozen in HALT.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; 5 cycles.
- R-type sub (funct 100010) -> EXECUTE drives alu_control=110, ALUWB drives reg_write=1, reg_dst=1; then beq with zero=1 -> pc_en=1, pc_src=01; with zero=0 -> pc_en=0.
- sw, mem_ready low for 3 cycles in MEMWR -> mem_req=mem_write=1 for 4 cycles, FSM returns to FETCH after ready.
- opcode 111111 -> HALT, halted=1, halt_cause=01, no strobes for 10 cycles; reset=0 one cycle -> FETCH, halt_cause=00.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> HALT with cause 11 after 4 wait cycles; repeat with mem_ready=1 exactly on cycle 4 -> DECODE, no halt.
- With MC_CONTROLLER_INSTRET_EN: run j, addi, lw -> instret=3; assert reset mid-MEMRD -> mem_req=0 immediately, instret=0, state=FETCH.
